// File: rtl/neuron_result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_result_writer_pkg
// Description : Shared definitions for the neuron result writer: FSM state
//               encodings and a clog2 helper used for parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_result_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Number of bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : write_addr_counter
// Description : Write-address counter with clock enable, synchronous
//               active-low reset, clear and increment. Clear wins over inc.
// Ports       : clk, clk_en, rst (active-low sync), inc, clr -> out[WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module write_addr_counter
    import neuron_result_writer_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clk_en) begin
            if (clr) begin
                r_count <= '0;
            end else if (inc) begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign out = r_count;

endmodule
`default_nettype wire

// File: rtl/neuron_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_result_writer
// Description : Captures NUM_NEURONS results on a layer-done pulse, optionally
//               clamps negatives to zero (ReLU), then streams them one per
//               acknowledged beat to addresses 0..NUM_NEURONS-1.
// Ports       : clk, rst (active-low sync), clk_en, in_ready, in_data
//               -> busy, wr_en, wr_addr, wr_data, done, overrun; wr_ack in.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_result_writer
    import neuron_result_writer_pkg::*;
#(
    parameter int NUM_NEURONS       = 30,
    parameter int CLOG2_NUM_NEURONS = 5,
    parameter int DATA_WIDTH        = 8,
    parameter int APPLY_RELU        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_en,
    input  logic                              in_ready,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    output logic                              busy,
    output logic                              wr_en,
    output logic [CLOG2_NUM_NEURONS-1:0]      wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              wr_ack,
    output logic                              done,
    output logic                              overrun
);

    localparam logic [CLOG2_NUM_NEURONS-1:0] c_last_addr = CLOG2_NUM_NEURONS'(NUM_NEURONS - 1);

    generate
        if (CLOG2_NUM_NEURONS < clog2(NUM_NEURONS)) begin : g_bad_addr_width
            $error("CLOG2_NUM_NEURONS too small for NUM_NEURONS");
        end
    endgenerate

    state_t                         r_state;
    logic                           r_overrun;
    logic [DATA_WIDTH-1:0]          r_shadow [NUM_NEURONS];
    logic [CLOG2_NUM_NEURONS-1:0]   w_addr;
    logic                           w_capture;
    logic                           w_beat;
    logic                           w_last;
    logic [DATA_WIDTH-1:0]          w_sel;

    assign w_capture = clk_en && in_ready && (r_state == S_IDLE);
    assign w_beat    = clk_en && wr_ack && (r_state == S_WRITE);
    assign w_last    = (w_addr == c_last_addr);

    // Clearing on the last beat returns the address to 0 without ever
    // stepping into codes beyond NUM_NEURONS-1.
    write_addr_counter #(
        .WIDTH (CLOG2_NUM_NEURONS)
    ) u_addr_counter (
        .clk    (clk),
        .clk_en (clk_en),
        .rst    (rst),
        .inc    (w_beat && !w_last),
        .clr    (w_capture || (w_beat && w_last)),
        .out    (w_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_overrun <= 1'b0;
        end else if (clk_en) begin
            if (in_ready && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE:  if (in_ready) r_state <= S_WRITE;
                S_WRITE: if (wr_ack && w_last) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shadow bank carries no reset: it is only observed after a capture.
    always_ff @(posedge clk) begin
        if (rst && w_capture) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_shadow[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Compare-based mux keeps the select width independent of array depth.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (w_addr == CLOG2_NUM_NEURONS'(i)) begin
                w_sel = r_shadow[i];
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign wr_en   = (r_state == S_WRITE);
    assign wr_addr = wr_en ? w_addr : '0;
    assign wr_data = ((APPLY_RELU != 0) && w_sel[DATA_WIDTH-1]) ? '0 : w_sel;
    assign done    = (r_state == S_DONE);
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_neuron_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_result_writer
// Description : Directed self-checking bench. dut_a (ReLU) and dut_b (raw)
//               share 4-neuron stimulus; dut_c uses the default 30 neurons.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        in_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        wr_ack = 1'b0;
    logic        in_ready_c = 1'b0;
    logic        wr_ack_c = 1'b0;
    logic [239:0] in_data_c = '0;

    logic       busy_a, wr_en_a, done_a, overrun_a;
    logic [4:0] wr_addr_a;
    logic [7:0] wr_data_a;
    logic       busy_b, wr_en_b, done_b, overrun_b;
    logic [4:0] wr_addr_b;
    logic [7:0] wr_data_b;
    logic       busy_c, wr_en_c, done_c, overrun_c;
    logic [4:0] wr_addr_c;
    logic [7:0] wr_data_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_relu [4] = '{8'h00, 8'h01, 8'h00, 8'h7F};
    logic [7:0] exp_raw  [4] = '{8'hFF, 8'h01, 8'h80, 8'h7F};

    always #5 clk = ~clk;

    neuron_result_writer #(.NUM_NEURONS(4), .CLOG2_NUM_NEURONS(5), .DATA_WIDTH(8), .APPLY_RELU(1)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_ready(in_ready), .in_data(in_data),
        .busy(busy_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .wr_ack(wr_ack), .done(done_a), .overrun(overrun_a));

    neuron_result_writer #(.NUM_NEURONS(4), .CLOG2_NUM_NEURONS(5), .DATA_WIDTH(8), .APPLY_RELU(0)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_ready(in_ready), .in_data(in_data),
        .busy(busy_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .wr_ack(wr_ack), .done(done_b), .overrun(overrun_b));

    neuron_result_writer dut_c (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_ready(in_ready_c), .in_data(in_data_c),
        .busy(busy_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
        .wr_ack(wr_ack_c), .done(done_c), .overrun(overrun_c));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step();
        n_checks++;
        if ({busy_a, wr_en_a, wr_addr_a, done_a, overrun_a, busy_b, wr_en_b, done_b, overrun_b} !== '0) begin
            n_errors++;
            $display("FAIL reset_ab: got %b expected 0", {busy_a, wr_en_a, wr_addr_a, done_a, overrun_a, busy_b, wr_en_b, done_b, overrun_b});
        end
        n_checks++;
        if ({busy_c, wr_en_c, wr_addr_c, done_c, overrun_c} !== '0) begin
            n_errors++;
            $display("FAIL reset_c: got %b expected 0", {busy_c, wr_en_c, wr_addr_c, done_c, overrun_c});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 30; i++) in_data_c[i*8 +: 8] = 8'(i + 1);
        in_ready_c = 1'b1;
        wr_ack_c   = 1'b1;
        step();
        in_ready_c = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if ({busy_c, wr_en_c, wr_addr_c, wr_data_c} !== {1'b1, 1'b1, 5'd5, 8'h06}) begin
            n_errors++;
            $display("FAIL mid_addr5: got %h expected %h", {busy_c, wr_en_c, wr_addr_c, wr_data_c}, {1'b1, 1'b1, 5'd5, 8'h06});
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({busy_c, wr_en_c, wr_addr_c, done_c, overrun_c} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: got %b expected 0", {busy_c, wr_en_c, wr_addr_c, done_c, overrun_c});
        end
        rst = 1'b1;
        in_ready_c = 1'b1;
        step();
        in_ready_c = 1'b0;
        wr_ack_c   = 1'b0;
        n_checks++;
        if ({busy_c, wr_en_c, wr_addr_c, wr_data_c} !== {1'b1, 1'b1, 5'd0, 8'h01}) begin
            n_errors++;
            $display("FAIL mid_restart: got %h expected %h", {busy_c, wr_en_c, wr_addr_c, wr_data_c}, {1'b1, 1'b1, 5'd0, 8'h01});
        end
    endtask

    task automatic test_stream;
        in_data  = {8'h7F, 8'h80, 8'h01, 8'hFF};
        in_ready = 1'b1;
        wr_ack   = 1'b1;
        step();
        in_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy_a, wr_en_a, wr_addr_a, wr_data_a, done_a} !== {1'b1, 1'b1, 5'(i), exp_relu[i], 1'b0}) begin
                n_errors++;
                $display("FAIL relu_beat%0d: got %h expected %h", i, {busy_a, wr_en_a, wr_addr_a, wr_data_a, done_a}, {1'b1, 1'b1, 5'(i), exp_relu[i], 1'b0});
            end
            n_checks++;
            if ({wr_en_b, wr_addr_b, wr_data_b} !== {1'b1, 5'(i), exp_raw[i]}) begin
                n_errors++;
                $display("FAIL raw_beat%0d: got %h expected %h", i, {wr_en_b, wr_addr_b, wr_data_b}, {1'b1, 5'(i), exp_raw[i]});
            end
            step();
        end
        n_checks++;
        if ({busy_a, wr_en_a, wr_addr_a, done_a, done_b} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL done_pulse: got %b expected %b", {busy_a, wr_en_a, wr_addr_a, done_a, done_b}, {1'b1, 1'b0, 5'd0, 1'b1, 1'b1});
        end
        step();
        n_checks++;
        if ({busy_a, done_a, busy_b, done_b, overrun_a} !== 5'b0) begin
            n_errors++;
            $display("FAIL after_done: got %b expected 00000", {busy_a, done_a, busy_b, done_b, overrun_a});
        end
    endtask

    task automatic test_ack_stall;
        in_ready = 1'b1;
        wr_ack   = 1'b1;
        step();
        in_ready = 1'b0;
        step();
        step();
        wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b} !== {1'b1, 5'd2, 8'h00, 1'b1, 5'd2, 8'h80}) begin
                n_errors++;
                $display("FAIL stall%0d: got %h expected %h", i, {wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b}, {1'b1, 5'd2, 8'h00, 1'b1, 5'd2, 8'h80});
            end
        end
        wr_ack = 1'b1;
        step();
        n_checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a} !== {1'b1, 5'd3, 8'h7F}) begin
            n_errors++;
            $display("FAIL stall_resume: got %h expected %h", {wr_en_a, wr_addr_a, wr_data_a}, {1'b1, 5'd3, 8'h7F});
        end
        step();
        n_checks++;
        if ({done_a, wr_en_a} !== 2'b10) begin
            n_errors++;
            $display("FAIL stall_done: got %b expected 10", {done_a, wr_en_a});
        end
        step();
    endtask

    task automatic test_clk_en;
        in_ready = 1'b1;
        wr_ack   = 1'b1;
        step();
        in_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clk_en = 1'b0;
            step();
            n_checks++;
            if ({wr_en_a, wr_addr_a, wr_data_b} !== {1'b1, 5'(i), exp_raw[i]}) begin
                n_errors++;
                $display("FAIL cen_hold%0d: got %h expected %h", i, {wr_en_a, wr_addr_a, wr_data_b}, {1'b1, 5'(i), exp_raw[i]});
            end
            clk_en = 1'b1;
            step();
            if (i < 3) begin
                n_checks++;
                if ({wr_en_a, wr_addr_a, wr_data_a} !== {1'b1, 5'(i + 1), exp_relu[i + 1]}) begin
                    n_errors++;
                    $display("FAIL cen_adv%0d: got %h expected %h", i, {wr_en_a, wr_addr_a, wr_data_a}, {1'b1, 5'(i + 1), exp_relu[i + 1]});
                end
            end
        end
        clk_en = 1'b0;
        step();
        n_checks++;
        if ({done_a, busy_a} !== 2'b11) begin
            n_errors++;
            $display("FAIL cen_done_hold: got %b expected 11", {done_a, busy_a});
        end
        clk_en = 1'b1;
        step();
        n_checks++;
        if ({done_a, busy_a} !== 2'b00) begin
            n_errors++;
            $display("FAIL cen_idle: got %b expected 00", {done_a, busy_a});
        end
    endtask

    task automatic test_overrun;
        in_data  = {8'h10, 8'h20, 8'h30, 8'h40};
        in_ready = 1'b1;
        wr_ack   = 1'b1;
        step();
        in_data  = 32'hAAAA_AAAA;
        step();
        in_ready = 1'b0;
        n_checks++;
        if ({overrun_a, overrun_b, wr_addr_a, wr_data_a, wr_data_b} !== {1'b1, 1'b1, 5'd1, 8'h30, 8'h30}) begin
            n_errors++;
            $display("FAIL overrun_set: got %h expected %h", {overrun_a, overrun_b, wr_addr_a, wr_data_a, wr_data_b}, {1'b1, 1'b1, 5'd1, 8'h30, 8'h30});
        end
        step();
        step();
        n_checks++;
        if ({wr_addr_b, wr_data_b} !== {5'd3, 8'h10}) begin
            n_errors++;
            $display("FAIL overrun_data: got %h expected %h", {wr_addr_b, wr_data_b}, {5'd3, 8'h10});
        end
        step();
        // In DONE: this pulse must be dropped.
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        n_checks++;
        if ({busy_a, busy_b, overrun_a} !== 3'b001) begin
            n_errors++;
            $display("FAIL done_exit_drop: got %b expected 001", {busy_a, busy_b, overrun_a});
        end
        in_data  = {8'h01, 8'h02, 8'h03, 8'h84};
        in_ready = 1'b1;
        wr_ack   = 1'b0;
        step();
        in_ready = 1'b0;
        n_checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a, wr_data_b, overrun_a} !== {1'b1, 5'd0, 8'h00, 8'h84, 1'b1}) begin
            n_errors++;
            $display("FAIL recapture: got %h expected %h", {wr_en_a, wr_addr_a, wr_data_a, wr_data_b, overrun_a}, {1'b1, 5'd0, 8'h00, 8'h84, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_stream();
        test_ack_stall();
        test_clk_en();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
